// File: rtl/or4_sweep_checker.sv
// Sweeps all 16 input vectors through a two-level OR4 gate and checks its e/f/g outputs.
// Optional macro OR4_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module or4_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       fail_vec,
  output logic [2:0]       fail_obs
);

  localparam int unsigned SCNT_W = 8;
  localparam int unsigned VEC_W  = 4;
  localparam int unsigned OBS_W  = 3;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t              state;
  logic [SCNT_W-1:0]   settle_cnt;
  logic [VEC_W-1:0]    vec;
  logic [OBS_W-1:0]    exp_obs;
  logic [OBS_W-1:0]    obs;
  logic                mismatch;
  logic                last_check;
  logic [CNT_W-1:0]    err_inc;

  // Stimulus comes straight from the vector register, so a..d only move on clock edges.
  assign {a, b, c, d} = vec;

  // Reference model of the gate and saturating error increment.
  always_comb begin
    exp_obs  = {vec[3] | vec[2], vec[1] | vec[0], |vec};
    obs      = {e, f, g};
    mismatch = (exp_obs != obs);
    err_inc  = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
`ifdef OR4_SWEEP_STOP_ON_FAIL_EN
    last_check = mismatch || (vec == VEC_W'(15));
`else
    last_check = (vec == VEC_W'(15));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_obs   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_obs   <= '0;
          end
        end

        SETTLE: begin
          if (settle_cnt == SCNT_W'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + SCNT_W'(1);
          end
        end

        CHECK: begin
          if (mismatch) begin
            err_cnt <= err_inc;
            // Only the first failing vector is recorded.
            if (err_cnt == '0) begin
              fail_vec <= vec;
              fail_obs <= obs;
            end
          end
          if (last_check) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mismatch && (err_cnt == '0);
          end else begin
            vec   <= vec + VEC_W'(1);
            state <= SETTLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or4_sweep_checker.sv
// Directed bench for or4_sweep_checker: table of sweeps plus reset, re-start and narrow-counter sequences.
module tb_or4_sweep_checker;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned SWEEP  = 16 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start3;
  logic       a, b, c, d, e, f, g, busy, done, pass;
  logic [7:0] err_cnt;
  logic [3:0] fail_vec;
  logic [2:0] fail_obs;
  logic       a3, b3, c3, d3, e3, f3, g3, busy3, done3, pass3;
  logic [2:0] err_cnt3;
  logic [3:0] fail_vec3;
  logic [2:0] fail_obs3;

  int mode, mode3;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  or4_sweep_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec), .fail_obs(fail_obs)
  );

  or4_sweep_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3), .g(g3),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err_cnt3), .fail_vec(fail_vec3), .fail_obs(fail_obs3)
  );

  // Gate models: 0 = correct, 1 = g stuck at 0, 2 = all outputs inverted.
  always_comb begin
    e = (mode == 2) ? ~(a | b) : (a | b);
    f = (mode == 2) ? ~(c | d) : (c | d);
    g = (mode == 1) ? 1'b0 : (mode == 2) ? ~(a | b | c | d) : (a | b | c | d);
    e3 = (mode3 == 2) ? ~(a3 | b3) : (a3 | b3);
    f3 = (mode3 == 2) ? ~(c3 | d3) : (c3 | d3);
    g3 = (mode3 == 1) ? 1'b0 : (mode3 == 2) ? ~(a3 | b3 | c3 | d3) : (a3 | b3 | c3 | d3);
  end

  typedef struct {
    int mode;
    bit repulse;
    int done_edge;
    int err;
    int fvec;
    int fobs;
    int pass;
  } rec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input rec_t r);
    int n;
    mode = r.mode;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    chk("start_vec", int'({a, b, c, d}), 0);
    chk("start_err_clr", int'(err_cnt), 0);
    n = 0;
    while (!done && n < 200) begin
      start = r.repulse && (n == 9);
      @(posedge clk);
      #1;
      n++;
      chk("busy_done_excl", int'(busy && done), 0);
      if (r.mode == 0 && (n % int'(SETTLE + 1)) == 0 && n < int'(SWEEP))
        chk("vec_seq", int'({a, b, c, d}), n / int'(SETTLE + 1));
    end
    start = 1'b0;
    chk("done_edge", n, r.done_edge);
    chk("end_busy", int'(busy), 0);
    chk("err_cnt", int'(err_cnt), r.err);
    chk("fail_vec", int'(fail_vec), r.fvec);
    chk("fail_obs", int'(fail_obs), r.fobs);
    chk("pass", int'(pass), r.pass);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", int'(done), 1);
    chk("err_hold", int'(err_cnt), r.err);
  endtask

  rec_t tbl[4];

  initial begin
    int n;
    tbl[0] = '{mode: 0, repulse: 1'b0, done_edge: SWEEP, err: 0, fvec: 0, fobs: 0, pass: 1};
`ifdef OR4_SWEEP_STOP_ON_FAIL_EN
    tbl[1] = '{mode: 1, repulse: 1'b0, done_edge: 6, err: 1, fvec: 1, fobs: 2, pass: 0};
    tbl[2] = '{mode: 2, repulse: 1'b0, done_edge: 3, err: 1, fvec: 0, fobs: 7, pass: 0};
`else
    tbl[1] = '{mode: 1, repulse: 1'b0, done_edge: SWEEP, err: 15, fvec: 1, fobs: 2, pass: 0};
    tbl[2] = '{mode: 2, repulse: 1'b0, done_edge: SWEEP, err: 16, fvec: 0, fobs: 7, pass: 0};
`endif
    tbl[3] = '{mode: 0, repulse: 1'b1, done_edge: SWEEP, err: 0, fvec: 0, fobs: 0, pass: 1};

    mode = 0;
    mode3 = 0;
    start = 1'b0;
    start3 = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vec", int'({a, b, c, d}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_fvec", int'(fail_vec), 0);
    chk("rst_fobs", int'(fail_obs), 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run(tbl[i]);

    // Abort mid-sweep while vector 5 is held, then resume from vector 0.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("pre_rst_vec", int'({a, b, c, d}), 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_vec", int'({a, b, c, d}), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle", int'(busy), 0);
    run(tbl[0]);

    // Narrow counter saturates when every vector fails.
    mode3 = 2;
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
`ifdef OR4_SWEEP_STOP_ON_FAIL_EN
    chk("c3_done_edge", n, 3);
    chk("c3_err", int'(err_cnt3), 1);
`else
    chk("c3_done_edge", n, int'(SWEEP));
    chk("c3_err", int'(err_cnt3), 7);
`endif
    chk("c3_fvec", int'(fail_vec3), 0);
    chk("c3_fobs", int'(fail_obs3), 7);
    chk("c3_pass", int'(pass3), 0);
    chk("c3_busy", int'(busy3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
